// File: rtl/serial_unnegate_10.sv
// Bit-serial receiver: recovers A = -N (mod 2^WIDTH) from N sent LSB-first.
// Copies bits up to and including the first 1, inverts every later bit.
module serial_unnegate_10 #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] A,
    output logic             A_valid,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // The final bit goes straight into A, so only WIDTH-1 bits need to be held.
    logic [WIDTH-2:0] sr_q, sr_d;
    logic             seen_q, seen_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             a_valid_q, a_valid_d;
    logic             ovf_q, ovf_d;
    logic             o_bit;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        seen_d    = seen_q;
        a_d       = a_q;
        ovf_d     = ovf_q;
        a_valid_d = 1'b0;
        o_bit     = bit_in ^ seen_q;

        if (bit_valid) begin
            if (start) begin
                state_d = SHIFT;
                cnt_d   = CW'(1);
                seen_d  = bit_in;
                sr_d    = {bit_in, {(WIDTH-2){1'b0}}};
            end else if (state_q == SHIFT) begin
                sr_d   = {o_bit, sr_q[WIDTH-2:1]};
                seen_d = seen_q | bit_in;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    a_d       = {o_bit, sr_q};
                    ovf_d     = bit_in & ~seen_q;
                    a_valid_d = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sr_q      <= '0;
            seen_q    <= 1'b0;
            a_q       <= '0;
            a_valid_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            seen_q    <= seen_d;
            a_q       <= a_d;
            a_valid_q <= a_valid_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy    = (state_q == SHIFT);
    assign A       = a_q;
    assign A_valid = a_valid_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_serial_unnegate_10.sv
// Self-checking bench for serial_unnegate_10: directed frames plus random frames
// with random gaps, compared against an arithmetic negation model.
module tb_serial_unnegate_10;

    logic       clk;
    logic       rst_n;
    logic       bit_valid;
    logic       bit_in;
    logic       start;
    logic       busy;
    logic [9:0] A;
    logic       A_valid;
    logic       ovf;

    int checks   = 0;
    int failures = 0;
    int strobes  = 0;

    serial_unnegate_10 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bit_valid(bit_valid),
        .bit_in   (bit_in),
        .start    (start),
        .busy     (busy),
        .A        (A),
        .A_valid  (A_valid),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (A_valid === 1'b1) strobes++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] model_a(input logic [9:0] n);
        int v;
        v = (1024 - int'(n)) % 1024;
        return v[9:0];
    endfunction

    // Inputs change on the falling edge; outputs are sampled on the falling edge.
    task automatic beat(input logic v, input logic s, input logic b);
        bit_valid = v;
        start     = s;
        bit_in    = b;
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        beat(1'b0, 1'b0, 1'b0);
        chk("a_valid_one_cycle", {31'd0, A_valid}, 32'd0);
    endtask

    // Sends the first nbits of n LSB-first; glen gap cycles after bits g1 and g2.
    task automatic send_bits(input logic [9:0] n, input int nbits,
                             input int g1, input int g2, input int glen);
        for (int i = 0; i < nbits; i++) begin
            beat(1'b1, i == 0, n[i]);
            if (i < 9) begin
                chk("busy_in_frame", {31'd0, busy}, 32'd1);
                chk("no_early_valid", {31'd0, A_valid}, 32'd0);
            end
            if (i < 9 && (i == g1 || i == g2)) begin
                for (int k = 0; k < glen; k++) begin
                    beat(1'b0, 1'b0, 1'($urandom));
                    chk("busy_in_gap", {31'd0, busy}, 32'd1);
                end
            end
        end
    endtask

    task automatic expect_result(input string tag, input logic [9:0] n);
        chk({tag, "_valid"}, {31'd0, A_valid}, 32'd1);
        chk({tag, "_A"}, {22'd0, A}, {22'd0, model_a(n)});
        chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, (n == 10'h200)});
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int s0;
        logic [9:0] n;
        rst_n     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        start     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_A", {22'd0, A}, 32'd0);
        chk("rst_valid", {31'd0, A_valid}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Non-start beats in IDLE are ignored.
        beat(1'b1, 1'b0, 1'b1);
        chk("idle_ignore_busy", {31'd0, busy}, 32'd0);

        send_bits(10'h3FB, 10, -1, -1, 0);
        expect_result("neg5", 10'h3FB);
        idle_cycle();

        send_bits(10'h000, 10, -1, -1, 0);
        expect_result("zero", 10'h000);
        idle_cycle();
        send_bits(10'h001, 10, -1, -1, 0);
        expect_result("one", 10'h001);
        idle_cycle();

        send_bits(10'h200, 10, -1, -1, 0);
        expect_result("min", 10'h200);
        idle_cycle();
        chk("ovf_held", {31'd0, ovf}, 32'd1);
        send_bits(10'h3FF, 10, -1, -1, 0);
        expect_result("after_min", 10'h3FF);
        idle_cycle();

        send_bits(10'h0C8, 10, 2, 7, 3);
        expect_result("gaps", 10'h0C8);
        idle_cycle();

        s0 = strobes;
        send_bits(10'h155, 4, -1, -1, 0);
        send_bits(10'h00A, 10, -1, -1, 0);
        expect_result("abort", 10'h00A);
        idle_cycle();
        chk("abort_strobes", strobes - s0, 32'd1);

        s0 = strobes;
        send_bits(10'h2AB, 6, -1, -1, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_A", {22'd0, A}, 32'd0);
        chk("midrst_valid", {31'd0, A_valid}, 32'd0);
        chk("midrst_ovf", {31'd0, ovf}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        idle_cycle();
        chk("midrst_strobes", strobes - s0, 32'd0);
        send_bits(10'h123, 10, -1, -1, 0);
        expect_result("post_rst", 10'h123);
        idle_cycle();

        s0 = strobes;
        send_bits(10'h3FB, 10, -1, -1, 0);
        expect_result("b2b_first", 10'h3FB);
        send_bits(10'h005, 10, -1, -1, 0);
        expect_result("b2b_second", 10'h005);
        idle_cycle();
        chk("b2b_strobes", strobes - s0, 32'd2);

        for (int f = 0; f < 40; f++) begin
            n = 10'($urandom_range(0, 1023));
            if (f % 8 == 0) n = 10'h200;
            send_bits(n, 10, int'($urandom_range(0, 8)), int'($urandom_range(0, 8)),
                      int'($urandom_range(0, 3)));
            expect_result("rand", n);
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
